// File: rtl/rx_frame_decoder.sv
// UART command-frame parser: SOF, NCH x {ID, NB data bytes}, XOR checksum.
// Channel words are committed to phase_bus together, and only when the whole frame checks out.
module rx_frame_decoder #(
  parameter int          NCH     = 4,
  parameter int          DW      = 10,
  parameter int          NB      = 2,
  parameter logic [7:0]  SOF     = 8'hA5,
  parameter int          TIMEOUT = 50000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              RX_Done_Sig,
  input  logic [7:0]        RX_Data,
  output logic              RX_En_Sig,
  output logic [NCH*DW-1:0] phase_bus,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              busy
);

  localparam int SW = 8 * NB;
  localparam int CW = $clog2(NCH + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_SOF = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_DAT = 3'd2;
  localparam logic [2:0] S_CS  = 3'd3;
  localparam logic [2:0] S_COM = 3'd4;
  localparam logic [2:0] S_ERR = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [SW-1:0]     shadow_q [NCH];
  logic [SW-1:0]     shadow_d [NCH];
  logic [NCH*DW-1:0] phase_q, phase_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              rx_en_q;
  logic              in_frame;
  logic              tmo_hit;

  assign in_frame = (state_q == S_ID) || (state_q == S_DAT) || (state_q == S_CS);
  assign tmo_hit  = (TIMEOUT > 0) && in_frame && !RX_Done_Sig && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
    state_d  = state_q;
    ch_d     = ch_q;
    bcnt_d   = bcnt_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    phase_d  = phase_q;
    tmo_d    = '0;

    // Idle counter only runs between bytes of a frame; any strobe restarts it.
    if ((TIMEOUT > 0) && in_frame && !RX_Done_Sig) tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_SOF: begin
        if (RX_Done_Sig && (RX_Data == SOF)) begin
          state_d = S_ID;
          ch_d    = CW'(1);
          csum_d  = '0;
        end
      end
      S_ID: begin
        if (RX_Done_Sig) begin
          csum_d = csum_q ^ RX_Data;
          if (RX_Data == 8'(ch_q)) begin
            state_d = S_DAT;
            bcnt_d  = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DAT: begin
        if (RX_Done_Sig) begin
          csum_d = csum_q ^ RX_Data;
          for (int k = 0; k < NCH; k++) begin
            if (ch_q == CW'(k + 1)) begin
              shadow_d[k]      = shadow_q[k] << 8;
              shadow_d[k][7:0] = RX_Data;
            end
          end
          if (bcnt_q == BW'(NB - 1)) begin
            if (ch_q == CW'(NCH)) begin
              state_d = S_CS;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = S_ID;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_CS: begin
        if (RX_Done_Sig) begin
          if (RX_Data == csum_q) begin
            state_d = S_COM;
            // Commit on the same edge that enters S_COM so data and frame_ok appear together.
            for (int k = 0; k < NCH; k++) phase_d[k*DW +: DW] = shadow_q[k][DW-1:0];
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_COM:   state_d = S_SOF;
      S_ERR:   state_d = S_SOF;
      default: state_d = S_SOF;
    endcase

    if (tmo_hit) begin
      state_d = S_ERR;
      tmo_d   = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_SOF;
      ch_q    <= '0;
      bcnt_q  <= '0;
      csum_q  <= '0;
      phase_q <= '0;
      tmo_q   <= '0;
      rx_en_q <= 1'b0;
      // NOTE: the shadow array is plain flop storage with a defined reset value, so it is cleared here too.
      for (int k = 0; k < NCH; k++) shadow_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      bcnt_q   <= bcnt_d;
      csum_q   <= csum_d;
      phase_q  <= phase_d;
      tmo_q    <= tmo_d;
      rx_en_q  <= 1'b1;
      shadow_q <= shadow_d;
    end
  end

  assign RX_En_Sig = rx_en_q;
  assign phase_bus = phase_q;
  assign frame_ok  = (state_q == S_COM);
  assign frame_err = (state_q == S_ERR);
  assign busy      = (state_q != S_SOF);

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Bench for rx_frame_decoder: a 4-channel instance (short timeout) and a 2-channel 12-bit instance (timeout off).
// Frame outcomes are queued when the last byte is driven and checked when frame_ok/frame_err appear.
module tb_rx_frame_decoder;
  localparam int A_W = 40;
  localparam int B_W = 24;
  localparam int TMO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn_a, rstn_b, done_a, done_b;
  logic [7:0]     data_a, data_b;
  logic           en_a, ok_a, err_a, busy_a;
  logic           en_b, ok_b, err_b, busy_b;
  logic [A_W-1:0] ph_a;
  logic [B_W-1:0] ph_b;

  rx_frame_decoder #(.NCH(4), .DW(10), .NB(2), .SOF(8'hA5), .TIMEOUT(TMO)) dut_a (
    .CLK(clk), .RSTn(rstn_a), .RX_Done_Sig(done_a), .RX_Data(data_a),
    .RX_En_Sig(en_a), .phase_bus(ph_a), .frame_ok(ok_a), .frame_err(err_a), .busy(busy_a));

  rx_frame_decoder #(.NCH(2), .DW(12), .NB(2), .SOF(8'hA5), .TIMEOUT(0)) dut_b (
    .CLK(clk), .RSTn(rstn_b), .RX_Done_Sig(done_b), .RX_Data(data_b),
    .RX_En_Sig(en_b), .phase_bus(ph_b), .frame_ok(ok_b), .frame_err(err_b), .busy(busy_b));

  typedef struct {
    logic [15:0][7:0] b;
    int               n;
    logic             ok;
    logic [A_W-1:0]   ph;
  } vec_t;

  typedef struct {
    logic           ok;
    logic [A_W-1:0] ph;
  } exp_t;

  exp_t           q_a[$];
  exp_t           q_b[$];
  int             tests = 0;
  int             fails = 0;
  logic [A_W-1:0] cur_a = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was sampled, so calls chain back-to-back.
  task automatic send_a(input logic [7:0] v);
    done_a = 1'b1;
    data_a = v;
    @(posedge clk);
    #1;
    done_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] v);
    done_b = 1'b1;
    data_b = v;
    @(posedge clk);
    #1;
    done_b = 1'b0;
  endtask

  task automatic push_a(input logic ok, input logic [A_W-1:0] ph);
    exp_t e;
    e.ok = ok;
    e.ph = ph;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic ok, input logic [A_W-1:0] ph);
    exp_t e;
    e.ok = ok;
    e.ph = ph;
    q_b.push_back(e);
  endtask

  // Reference frame for the 4x10-bit instance; checksum and truncated words computed here.
  function automatic vec_t frame_a(input logic [15:0] w0, w1, w2, w3);
    vec_t        v;
    logic [15:0] w [4];
    logic [7:0]  cs;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    v.b    = '0;
    v.b[0] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      v.b[1+3*k] = 8'(k + 1);
      v.b[2+3*k] = w[k][15:8];
      v.b[3+3*k] = w[k][7:0];
    end
    cs = '0;
    for (int j = 1; j < 13; j++) cs ^= v.b[j];
    v.b[13] = cs;
    v.n     = 14;
    v.ok    = 1'b1;
    v.ph    = {w[3][9:0], w[2][9:0], w[1][9:0], w[0][9:0]};
    return v;
  endfunction

  // Scoreboard: every frame_ok/frame_err cycle consumes one queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn_a && (ok_a || err_a)) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_event", {62'd0, ok_a, err_a}, 64'd0);
      end else begin
        e = q_a.pop_front();
        check("a_event_ok", {63'd0, ok_a}, {63'd0, e.ok});
        check("a_event_err", {63'd0, err_a}, {63'd0, !e.ok});
        check("a_event_phase", {24'd0, ph_a}, {24'd0, e.ph});
      end
    end
    if (rstn_b && (ok_b || err_b)) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_event", {62'd0, ok_b, err_b}, 64'd0);
      end else begin
        e = q_b.pop_front();
        check("b_event_ok", {63'd0, ok_b}, {63'd0, e.ok});
        check("b_event_err", {63'd0, err_b}, {63'd0, !e.ok});
        check("b_event_phase", {40'd0, ph_b}, {24'd0, e.ph});
      end
    end
  end

  initial begin
    vec_t       tbl [6];
    vec_t       t1;
    int         n;
    logic [7:0] cs;

    t1 = frame_a(16'h0123, 16'h0010, 16'h03FF, 16'h0000);
    tbl[0] = t1;
    tbl[1] = t1; tbl[1].b[13] = 8'h35; tbl[1].ok = 1'b0;
    tbl[2] = t1; tbl[2].b[1] = 8'h02; tbl[2].n = 2; tbl[2].ok = 1'b0;
    tbl[3] = t1;
    tbl[4] = frame_a(16'hFFFF, 16'h02AA, 16'h00A5, 16'h0155);
    tbl[5] = frame_a(16'h0001, 16'h0002, 16'h0003, 16'h0004); tbl[5].b[7] = 8'h04; tbl[5].n = 8; tbl[5].ok = 1'b0;

    rstn_a = 1'b0; rstn_b = 1'b0;
    done_a = 1'b0; done_b = 1'b0;
    data_a = '0;   data_b = '0;
    #1;
    check("rst_phase_a", {24'd0, ph_a}, 64'd0);
    check("rst_flags_a", {60'd0, en_a, ok_a, err_a, busy_a}, 64'd0);
    check("rst_phase_b", {40'd0, ph_b}, 64'd0);
    check("rst_flags_b", {60'd0, en_b, ok_b, err_b, busy_b}, 64'd0);
    @(negedge clk);
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(posedge clk);
    #1;
    check("rx_en_a_after_reset", {63'd0, en_a}, 64'd1);
    check("rx_en_b_after_reset", {63'd0, en_b}, 64'd1);
    idle(2);

    // Commit latency and single-cycle frame_ok pulse.
    for (int j = 0; j < 13; j++) send_a(t1.b[j]);
    check("t1_busy_in_frame", {63'd0, busy_a}, 64'd1);
    check("t1_no_early_commit", {24'd0, ph_a}, 64'd0);
    send_a(t1.b[13]);
    push_a(1'b1, t1.ph);
    cur_a = t1.ph;
    @(negedge clk);
    check("t1_ok_next_cycle", {63'd0, ok_a}, 64'd1);
    check("t1_phase", {24'd0, ph_a}, {24'd0, t1.ph});
    @(negedge clk);
    check("t1_ok_one_cycle", {63'd0, ok_a}, 64'd0);
    check("t1_busy_after", {63'd0, busy_a}, 64'd0);
    idle(2);

    // Wrong ID: frame_err on the edge after the bad ID byte.
    send_a(8'hA5);
    send_a(8'h02);
    push_a(1'b0, cur_a);
    @(negedge clk);
    check("t3_err_next_cycle", {63'd0, err_a}, 64'd1);
    idle(3);

    // Table of frames, including junk bytes ahead of a SOF.
    send_a(8'h00); send_a(8'h13); send_a(8'h5A);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tbl[i].n; j++) send_a(tbl[i].b[j]);
      push_a(tbl[i].ok, tbl[i].ok ? tbl[i].ph : cur_a);
      if (tbl[i].ok) cur_a = tbl[i].ph;
      idle(3);
    end

    // Inter-byte timeout after 5 bytes.
    for (int j = 0; j < 5; j++) send_a(t1.b[j]);
    push_a(1'b0, cur_a);
    n = 0;
    while (n < 3 * TMO) begin
      @(negedge clk);
      if (err_a) break;
      n++;
    end
    check("t4_idle_cycles_to_err", 64'(n), 64'(TMO));
    @(negedge clk);
    check("t4_busy_dropped", {63'd0, busy_a}, 64'd0);
    check("t4_phase_kept", {24'd0, ph_a}, {24'd0, cur_a});
    @(posedge clk);
    #1;

    // Reset in the middle of a frame, then a clean frame.
    send_a(8'hA5); send_a(8'h01); send_a(8'h01);
    rstn_a = 1'b0;
    #1;
    check("t6_phase_cleared", {24'd0, ph_a}, 64'd0);
    check("t6_flags_cleared", {60'd0, en_a, ok_a, err_a, busy_a}, 64'd0);
    cur_a = '0;
    @(negedge clk);
    rstn_a = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rx_en_back", {63'd0, en_a}, 64'd1);
    for (int j = 0; j < 14; j++) send_a(tbl[4].b[j]);
    push_a(1'b1, tbl[4].ph);
    cur_a = tbl[4].ph;
    idle(3);

    // 2x12-bit instance: junk, truncation of the upper nibble, and no timeout.
    send_b(8'h00); send_b(8'hFF); send_b(8'h13);
    send_b(8'hA5); send_b(8'h01); send_b(8'hFF); send_b(8'hFF);
    send_b(8'h02); send_b(8'h0A); send_b(8'hBC);
    send_b(8'h01 ^ 8'hFF ^ 8'hFF ^ 8'h02 ^ 8'h0A ^ 8'hBC);
    push_b(1'b1, {16'd0, 12'hABC, 12'hFFF});
    idle(3);
    cs = 8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h02 ^ 8'h00 ^ 8'h07;
    send_b(8'hA5); send_b(8'h01); send_b(8'h12);
    idle(300);
    check("b_no_timeout_busy", {63'd0, busy_b}, 64'd1);
    send_b(8'h34); send_b(8'h02); send_b(8'h00); send_b(8'h07); send_b(cs);
    push_b(1'b1, {16'd0, 12'h007, 12'h234});
    idle(3);

    n = 0;
    while (((q_a.size() + q_b.size()) != 0) && (n < 1000)) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
